hazard_scoreboard: RTL

- Producer-side companion to the EX-stage forwarding unit: tracks in-flight register writes whose results cannot yet be forwarded (loads, multi-cycle multiplies).
- Sits in ID. Stalls PC and IF/ID, and injects a bubble into ID/EX, until every source of the ID instruction is forwardable from EX/MEM or MEM/WB.
- Covers load-use, multiply-use, WAW-on-multiply and multiplier structural hazards. Register file is 16 x 4-bit addressed; r0 is never tracked.

---
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage scoreboard for load/multiply result latency
// Holds the ID instruction until every source it reads is forwardable from EX/MEM or MEM/WB.
module hazard_scoreboard #(
  parameter int MUL_LAT  = 4,
  parameter int LOAD_LAT = 1,
  parameter int CW       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic        id_useRs,
  input  logic        id_useRt,
  input  logic [3:0]  id_rd,
  input  logic        id_regWr,
  input  logic        id_isLoad,
  input  logic        id_isMul,
  input  logic        flush,
  output logic        stall,
  output logic        bubble,
  output logic        mul_busy,
  output logic [15:0] stall_count
);

  localparam logic [CW-1:0] MUL_INIT  = CW'(MUL_LAT);
  localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_LAT);

  logic [CW-1:0] cnt_q [1:15];
  logic [CW-1:0] cnt_d [1:15];
  logic [CW-1:0] mul_cnt_q;
  logic [CW-1:0] mul_cnt_d;
  logic [15:0]   stall_count_q;
  logic [15:0]   stall_count_d;

  logic [15:0]   pend_vec;
  logic          hz_src;
  logic          hz_waw;
  logic          hz_struct;
  logic          hz;
  logic          issue;
  logic          wr_track;

  // pend_vec[0] stays low so r0 never stalls a reader or a writer.
  always_comb begin
    pend_vec = '0;
    for (int r = 1; r < 16; r++) begin
      pend_vec[r] = (cnt_q[r] != '0);
    end
  end

  always_comb begin
    mul_busy  = (mul_cnt_q != '0);
    hz_src    = (id_useRs & pend_vec[id_rs]) | (id_useRt & pend_vec[id_rt]);
    hz_waw    = id_regWr & pend_vec[id_rd];
    hz_struct = id_isMul & mul_busy;
    hz        = hz_src | hz_waw | hz_struct;
    stall     = id_valid & ~flush & hz;
    bubble    = stall | (id_valid & flush);
    issue     = id_valid & ~flush & ~hz;
    wr_track  = issue & id_regWr & (id_isMul | id_isLoad);
  end

  // A set can never meet a decrement on the same entry: WAW blocks issue while cnt[rd] != 0.
  always_comb begin
    for (int r = 1; r < 16; r++) begin
      cnt_d[r] = cnt_q[r];
      if (wr_track && (id_rd == 4'(r))) begin
        cnt_d[r] = id_isMul ? MUL_INIT : LOAD_INIT;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_comb begin
    mul_cnt_d = mul_cnt_q;
    if (issue && id_isMul) begin
      mul_cnt_d = MUL_INIT;
    end else if (mul_cnt_q != '0) begin
      mul_cnt_d = mul_cnt_q - 1'b1;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 16; r++) begin
        cnt_q[r] <= '0;
      end
      mul_cnt_q     <= '0;
      stall_count_q <= '0;
    end else begin
      for (int r = 1; r < 16; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      mul_cnt_q     <= mul_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
